// File: rtl/cavlc_pkg.sv
// -----------------------------------------------------------------------------
// cavlc_pkg
// Shared definitions for the CAVLC coeff_token encoder/decoder pair.
//   VLC0_MAX_LEN      : longest codeword of the 0 <= nC < 2 table (16 bits)
//   VLC0_LEN_W        : width that holds a codeword length 0..16
//   cavlc_dec_state_t : bit-serial decoder states
//   cavlc_token_t     : decoded/encoded token fields {TotalCoeff, TrailingOnes}
// -----------------------------------------------------------------------------
package cavlc_pkg;

   localparam int VLC0_MAX_LEN = 16;
   localparam int VLC0_LEN_W   = 5;

   typedef enum logic {
      ACCUM   = 1'b0,   // collecting bitstream bits
      PRESENT = 1'b1    // holding a token until downstream takes it
   } cavlc_dec_state_t;

   typedef struct packed {
      logic [4:0] total_coeff;    // 0..16
      logic [1:0] trailing_ones;  // 0..3
   } cavlc_token_t;

endpackage

// File: rtl/coeff_token_vlc0_match.sv
// -----------------------------------------------------------------------------
// coeff_token_vlc0_match
// Purely combinational lookup of the coeff_token VLC0 table (0 <= nC < 2).
// A codeword hits only when len equals its exact length and the low len bits
// of sr equal the codeword. The table is prefix-free, so at most one entry hits.
// Ports:
//   len   in  [LEN_W-1:0]        number of valid bits in sr (1..16)
//   sr    in  [VLC0_MAX_LEN-1:0] received bits, newest bit in sr[0]
//   hit   out                    a complete codeword is present
//   tok   out cavlc_token_t      TotalCoeff / TrailingOnes of the hit entry
// -----------------------------------------------------------------------------
module coeff_token_vlc0_match
   import cavlc_pkg::*;
#(
   parameter int LEN_W = VLC0_LEN_W
) (
   input  logic [LEN_W-1:0]        len,
   input  logic [VLC0_MAX_LEN-1:0] sr,
   output logic                    hit,
   output cavlc_token_t            tok
);

   logic [VLC0_MAX_LEN-1:0] code;
   logic [20:0]             key;

   // Keep only the low len bits; for len == 16 the shift wraps to 0 and the
   // subtraction yields an all-ones mask.
   always_comb begin
      code = sr & ((16'h1 << len) - 16'h1);
      key  = {5'(len), code};
   end

   always_comb begin
      hit = 1'b1;
      tok = '0;
      unique case (key)
         {5'd1,  16'd1}:  tok = '{5'd0,  2'd0};
         {5'd2,  16'd1}:  tok = '{5'd1,  2'd1};
         {5'd3,  16'd1}:  tok = '{5'd2,  2'd2};
         {5'd5,  16'd3}:  tok = '{5'd3,  2'd3};
         {5'd6,  16'd5}:  tok = '{5'd1,  2'd0};
         {5'd6,  16'd4}:  tok = '{5'd2,  2'd1};
         {5'd6,  16'd3}:  tok = '{5'd4,  2'd3};
         {5'd7,  16'd5}:  tok = '{5'd3,  2'd2};
         {5'd7,  16'd4}:  tok = '{5'd5,  2'd3};
         {5'd8,  16'd7}:  tok = '{5'd2,  2'd0};
         {5'd8,  16'd6}:  tok = '{5'd3,  2'd1};
         {5'd8,  16'd5}:  tok = '{5'd4,  2'd2};
         {5'd8,  16'd4}:  tok = '{5'd6,  2'd3};
         {5'd9,  16'd7}:  tok = '{5'd3,  2'd0};
         {5'd9,  16'd6}:  tok = '{5'd4,  2'd1};
         {5'd9,  16'd5}:  tok = '{5'd5,  2'd2};
         {5'd9,  16'd4}:  tok = '{5'd7,  2'd3};
         {5'd10, 16'd7}:  tok = '{5'd4,  2'd0};
         {5'd10, 16'd6}:  tok = '{5'd5,  2'd1};
         {5'd10, 16'd5}:  tok = '{5'd6,  2'd2};
         {5'd10, 16'd4}:  tok = '{5'd8,  2'd3};
         {5'd11, 16'd7}:  tok = '{5'd5,  2'd0};
         {5'd11, 16'd6}:  tok = '{5'd6,  2'd1};
         {5'd11, 16'd5}:  tok = '{5'd7,  2'd2};
         {5'd11, 16'd4}:  tok = '{5'd9,  2'd3};
         {5'd13, 16'd15}: tok = '{5'd6,  2'd0};
         {5'd13, 16'd11}: tok = '{5'd7,  2'd0};
         {5'd13, 16'd14}: tok = '{5'd7,  2'd1};
         {5'd13, 16'd8}:  tok = '{5'd8,  2'd0};
         {5'd13, 16'd10}: tok = '{5'd8,  2'd1};
         {5'd13, 16'd13}: tok = '{5'd8,  2'd2};
         {5'd13, 16'd9}:  tok = '{5'd9,  2'd2};
         {5'd13, 16'd12}: tok = '{5'd10, 2'd3};
         {5'd14, 16'd15}: tok = '{5'd9,  2'd0};
         {5'd14, 16'd14}: tok = '{5'd9,  2'd1};
         {5'd14, 16'd11}: tok = '{5'd10, 2'd0};
         {5'd14, 16'd10}: tok = '{5'd10, 2'd1};
         {5'd14, 16'd13}: tok = '{5'd10, 2'd2};
         {5'd14, 16'd9}:  tok = '{5'd11, 2'd2};
         {5'd14, 16'd12}: tok = '{5'd11, 2'd3};
         {5'd14, 16'd8}:  tok = '{5'd12, 2'd3};
         {5'd15, 16'd15}: tok = '{5'd11, 2'd0};
         {5'd15, 16'd14}: tok = '{5'd11, 2'd1};
         {5'd15, 16'd11}: tok = '{5'd12, 2'd0};
         {5'd15, 16'd10}: tok = '{5'd12, 2'd1};
         {5'd15, 16'd13}: tok = '{5'd12, 2'd2};
         {5'd15, 16'd1}:  tok = '{5'd13, 2'd1};
         {5'd15, 16'd9}:  tok = '{5'd13, 2'd2};
         {5'd15, 16'd12}: tok = '{5'd13, 2'd3};
         {5'd15, 16'd8}:  tok = '{5'd14, 2'd3};
         {5'd16, 16'd15}: tok = '{5'd13, 2'd0};
         {5'd16, 16'd11}: tok = '{5'd14, 2'd0};
         {5'd16, 16'd14}: tok = '{5'd14, 2'd1};
         {5'd16, 16'd13}: tok = '{5'd14, 2'd2};
         {5'd16, 16'd7}:  tok = '{5'd15, 2'd0};
         {5'd16, 16'd10}: tok = '{5'd15, 2'd1};
         {5'd16, 16'd9}:  tok = '{5'd15, 2'd2};
         {5'd16, 16'd12}: tok = '{5'd15, 2'd3};
         {5'd16, 16'd4}:  tok = '{5'd16, 2'd0};
         {5'd16, 16'd6}:  tok = '{5'd16, 2'd1};
         {5'd16, 16'd5}:  tok = '{5'd16, 2'd2};
         {5'd16, 16'd8}:  tok = '{5'd16, 2'd3};
         default:         hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/coeff_token_vlc0_decoder.sv
// -----------------------------------------------------------------------------
// coeff_token_vlc0_decoder
// Bit-serial CAVLC coeff_token decoder for the VLC0 table (0 <= nC < 2).
// Accepts one bitstream bit per handshake, MSB-first, and presents a token as
// soon as the accumulated prefix forms a complete codeword (zero extra cycles).
// If no codeword matches within MAX_LEN bits an error token is presented.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The bit side accepts only in ACCUM with flush low; the token side
// holds tok_valid and all fields stable until tok_ready is seen.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous abort of a partial codeword (ignored in PRESENT)
//   bit_in          next bitstream bit
//   bit_valid/ready bit handshake
//   tok_valid/ready token handshake
//   total_coeff     TotalCoeff 0..16
//   trailing_ones   TrailingOnes 0..3
//   code_len        bits consumed by this token 1..16
//   tok_err         token is invalid (no match within MAX_LEN bits)
//   dbg_state       current FSM state
// -----------------------------------------------------------------------------
module coeff_token_vlc0_decoder
   import cavlc_pkg::*;
#(
   parameter int MAX_LEN = VLC0_MAX_LEN,  // fixed by the standard
   parameter int LEN_W   = VLC0_LEN_W     // 2**LEN_W must exceed MAX_LEN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             bit_ready,
   output logic             tok_valid,
   input  logic             tok_ready,
   output logic [4:0]       total_coeff,
   output logic [1:0]       trailing_ones,
   output logic [LEN_W-1:0] code_len,
   output logic             tok_err,
   output cavlc_dec_state_t dbg_state
);

   cavlc_dec_state_t state_q, state_d;

   // Only MAX_LEN-1 bits are ever stored: the MAX_LEN-th bit always ends the
   // codeword (hit or error) and clears the register.
   logic [MAX_LEN-2:0] sr_q,       sr_d;
   logic [LEN_W-1:0]   len_q,      len_d;
   cavlc_token_t       tok_q,      tok_d;
   logic [LEN_W-1:0]   code_len_q, code_len_d;
   logic               tok_err_q,  tok_err_d;

   logic [MAX_LEN-1:0] next_sr;
   logic [LEN_W-1:0]   next_len;
   logic               m_hit;
   cavlc_token_t       m_tok;

   // Lookup is evaluated on the prefix including the bit offered this cycle,
   // which is what gives zero decode latency after the final bit.
   always_comb begin
      next_sr  = {sr_q, bit_in};
      next_len = len_q + LEN_W'(1);
   end

   coeff_token_vlc0_match #(
      .LEN_W (LEN_W)
   ) u_match (
      .len (next_len),
      .sr  (next_sr),
      .hit (m_hit),
      .tok (m_tok)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ACCUM;
         sr_q       <= '0;
         len_q      <= '0;
         tok_q      <= '0;
         code_len_q <= '0;
         tok_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         len_q      <= len_d;
         tok_q      <= tok_d;
         code_len_q <= code_len_d;
         tok_err_q  <= tok_err_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      len_d      = len_q;
      tok_d      = tok_q;
      code_len_d = code_len_q;
      tok_err_d  = tok_err_q;

      unique case (state_q)
         ACCUM: begin
            if (flush) begin
               // Flush beats a simultaneous bit: the bit is not consumed.
               sr_d  = '0;
               len_d = '0;
            end else if (bit_valid) begin
               if (m_hit) begin
                  tok_d      = m_tok;
                  code_len_d = next_len;
                  tok_err_d  = 1'b0;
                  sr_d       = '0;
                  len_d      = '0;
                  state_d    = PRESENT;
               end else if (next_len == LEN_W'(MAX_LEN)) begin
                  tok_d      = '0;
                  code_len_d = LEN_W'(MAX_LEN);
                  tok_err_d  = 1'b1;
                  sr_d       = '0;
                  len_d      = '0;
                  state_d    = PRESENT;
               end else begin
                  sr_d  = next_sr[MAX_LEN-2:0];
                  len_d = next_len;
               end
            end
         end
         PRESENT: begin
            // Flush has no effect here; the token must be taken first.
            if (tok_ready) begin
               state_d = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   // Outputs; token fields keep their last values after the handshake.
   always_comb begin
      bit_ready     = (state_q == ACCUM) && !flush;
      tok_valid     = (state_q == PRESENT);
      total_coeff   = tok_q.total_coeff;
      trailing_ones = tok_q.trailing_ones;
      code_len      = code_len_q;
      tok_err       = tok_err_q;
      dbg_state     = state_q;
   end

endmodule

// File: doc/coeff_token_vlc0_decoder.md
# coeff_token_vlc0_decoder

Bit-serial decoder for the CAVLC coeff_token syntax element using H.264 Table 9-5, column 0 ≤ nC < 2 (VLC0). It accepts one bitstream bit per handshake and accumulates bits until the prefix matches a complete codeword. It then emits TotalCoeff, TrailingOnes and the code length. It is the receive-side counterpart of the VLC0 coeff_token encoder table, and serves as the bitstream checker in the CAVLC loopback bench and as the first stage of the future residual-block parser.

## Interface
- `MAX_LEN`, 16: longest VLC0 codeword in bits. Fixed by the standard; exposed for width derivation only.
- `LEN_W`, 5: width of the length counter and `code_len`. Must satisfy 2^LEN_W > MAX_LEN.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous abort of any partial codeword.
- `bit_in` in 1: next bitstream bit, MSB-first order of the codeword.
- `bit_valid` in 1: `bit_in` is valid.
- `bit_ready` out 1: decoder accepts a bit this cycle.
- `tok_valid` out 1: a token result is presented.
- `tok_ready` in 1: downstream accepts the token.
- `total_coeff` out 5: decoded TotalCoeff, 0..16.
- `trailing_ones` out 2: decoded TrailingOnes, 0..3.
- `code_len` out LEN_W: number of bits consumed by this token, 1..16.
- `tok_err` out 1: qualifies a token as invalid, meaning no match within MAX_LEN bits.

## Operation
- **States:** ACCUM and PRESENT.
- **Reset:** state ACCUM, shift register 0, length counter 0, `tok_valid` 0, `total_coeff` 0, `trailing_ones` 0, `code_len` 0, `tok_err` 0.
- **`bit_ready`:** equals (state == ACCUM) && !flush.
- **ACCUM, bit accepted** (`bit_valid && bit_ready`):
  - next_sr = {sr[MAX_LEN-2:0], bit_in}; next_len = len + 1.
  - The match lookup is evaluated on (next_len, next_sr).
  - On hit: register the token fields, set `code_len` = next_len and `tok_err` = 0, clear sr and len, go to PRESENT.
  - On no hit with next_len == MAX_LEN: set `tok_err` = 1, `total_coeff` = 0, `trailing_ones` = 0, `code_len` = MAX_LEN, clear sr and len, go to PRESENT.
  - Otherwise store next_sr and next_len, and stay in ACCUM.
- **PRESENT:**
  - Hold `tok_valid` = 1 and all token fields stable.
  - When `tok_ready` is high, go to ACCUM and drop `tok_valid` on the following cycle.
  - Token fields keep their last values after the handshake. Only `tok_valid` qualifies them.
- **Flush:**
  - In ACCUM, flush clears sr and len and no bit is accepted. Flush and `bit_valid` in the same cycle: flush wins and the bit is not consumed.
  - In PRESENT, flush is ignored. The pending token must still be handshaken.
- **Match rule:** a codeword matches only when len equals its exact length and the low len bits of sr equal the codeword. VLC0 is prefix-free, so at most one entry hits for a given (len, sr).
- **Table entry count:** exactly 62 valid entries, i.e. every (TrailingOnes, TotalCoeff) pair with TrailingOnes ≤ min(TotalCoeff, 3).

## Timing
- A bit accepted at edge k that completes a codeword gives `tok_valid` = 1 from edge k onward, i.e. visible in cycle k+1.
- Decode latency is 0 cycles after the final bit.
- Throughput: an L-bit codeword needs L accept cycles plus at least 1 PRESENT cycle. `bit_ready` is 0 throughout PRESENT.
- **Backpressure:** `tok_ready` low holds PRESENT indefinitely with the outputs constant.
- **Reset mid-codeword:** partial bits are discarded immediately and the decoder returns to the reset values asynchronously.
- **Counter width:** len never exceeds MAX_LEN, and no wrap-around is reachable.

## Structure
- `cavlc_pkg` holds:
  - `VLC0_MAX_LEN` = 16.
  - The state enum `cavlc_dec_state_t` {ACCUM, PRESENT}.
  - The token struct {total_coeff[4:0], trailing_ones[1:0]}, shared with the encoder side.
- Sub-module `coeff_token_vlc0_match`: purely combinational lookup.
  - Inputs: len, sr.
  - Outputs: hit, total_coeff, trailing_ones.
  - Contains the 62-entry table.
- The top level holds the FSM, shift register, counter and output registers.

## Test plan
- **Shortest code:** bits "1" with `tok_ready` held 1 → the cycle after the accept shows `tok_valid` = 1, TC = 0, T1 = 0, len = 1; `bit_ready` returns to 1 one cycle later.
- **Back-to-back codes:** bits "01", "001", "00011" → tokens (TC1, T1 1, len2), (TC2, T1 2, len3), (TC3, T1 3, len5), in order, with no bit lost.
- **Longer codes:**
  - "000101" → TC1, T1 0, len6.
  - "00000111" → TC2, T1 0, len8.
- **Invalid input:** 16 consecutive zeros → `tok_err` = 1, len16, TC0, T1 0. The decoder then decodes a following "1" as TC0, T1 0, len1.
- **Backpressure:** "001" followed by `tok_ready` low for 3 cycles → outputs constant and `bit_ready` = 0 for those 3 cycles. Bits offered during that window are not consumed.
- **Flush and reset mid-codeword:**
  - "000", then flush with `bit_valid` = 1 in the same cycle, then "1" → token TC0, T1 0, len1.
  - Asserting `rst_n` low after "0000" → all outputs return to 0 immediately.
